// File: rtl/nios_sys_pio_pkg.sv
// Shared definitions for the Nios II system PIO slaves: register map,
// edge-type encoding and the post-reset warm-up sequence.
package nios_sys_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_RSVD     = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // Warm-up counter after reset release; edge detection is enabled only
  // once WARM_DONE is reached.
  typedef enum logic [1:0] {
    WARM_0    = 2'd0,
    WARM_1    = 2'd1,
    WARM_2    = 2'd2,
    WARM_DONE = 2'd3
  } warm_e;

endpackage

// File: rtl/nios_sys_pio_dtmf_key_in_if.sv
// Avalon-MM slave bus for the DTMF key-in PIO (read latency 0) plus its
// level interrupt.
interface nios_sys_pio_dtmf_key_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/nios_sys_pio_debounce.sv
// Single-bit stable-count filter: the output follows the input only after
// the input has differed from the output for DEBOUNCE_CYCLES consecutive
// clocks. Used by the key-in PIO when NIOS_SYS_PIO_DTMF_KEY_IN_DEBOUNCE_EN
// is defined.
module nios_sys_pio_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_q;

  // Count consecutive mismatches; commit the new level on the last one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_q   <= 1'b0;
    end else if (i_d == r_q) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      r_cnt <= '0;
      r_q   <= i_d;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/nios_sys_pio_dtmf_key_in.sv
// Avalon-MM input PIO for the DTMF receiver (Q1..Q4 tone code + StD).
// Inputs are double-synchronised, optionally debounced, edge-detected into
// a sticky W1C capture register, and gated by IRQ_MASK onto irq.
// Optional debounce filter: define NIOS_SYS_PIO_DTMF_KEY_IN_DEBOUNCE_EN.
module nios_sys_pio_dtmf_key_in
  import nios_sys_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 5,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_port,
  nios_sys_pio_dtmf_key_in_if.slave  avs
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] w_sample;
  logic [WIDTH-1:0] w_edge_raw;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clear;
  logic [31:0]      w_rdata;
  logic             w_wr;
  logic             w_unused_wdata;
  warm_e            r_warm;
  warm_e            w_warm_nxt;

  assign w_wr           = avs.chipselect & ~avs.write_n;
  assign w_unused_wdata = ^avs.writedata;

  // Two-flop synchroniser and previous-sample register for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
      r_prev  <= w_sample;
    end
  end

`ifdef NIOS_SYS_PIO_DTMF_KEY_IN_DEBOUNCE_EN
  for (genvar g = 0; g < WIDTH; g++) begin : g_debounce
    nios_sys_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .i_d   (r_sync2[g]),
      .o_q   (w_sample[g])
    );
  end
`else
  // Without the filter the second synchroniser stage is the sample, so DATA
  // shows a new level one edge before the capture register sets.
  assign w_sample = r_sync2;
`endif

  // Warm-up state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_warm <= WARM_0;
    else       r_warm <= w_warm_nxt;
  end

  // Warm-up next state: advance once per clock and stick at WARM_DONE.
  always_comb begin
    w_warm_nxt = r_warm;
    case (r_warm)
      WARM_0:    w_warm_nxt = WARM_1;
      WARM_1:    w_warm_nxt = WARM_2;
      WARM_2:    w_warm_nxt = WARM_DONE;
      default:   w_warm_nxt = WARM_DONE;
    endcase
  end

  // Per-bit edge detect of the selected polarity, suppressed during warm-up.
  always_comb begin
    w_edge_raw = '0;
    case (EDGE_TYPE)
      EDGE_FALL: w_edge_raw = ~w_sample & r_prev;
      EDGE_ANY:  w_edge_raw = w_sample ^ r_prev;
      default:   w_edge_raw = w_sample & ~r_prev;
    endcase
    w_edge = (r_warm == WARM_DONE) ? w_edge_raw : '0;
  end

  assign w_clear = (w_wr && avs.address == ADDR_EDGE_CAP) ? avs.writedata[WIDTH-1:0] : '0;

  // IRQ mask and edge capture; a fresh edge wins over a same-cycle W1C clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask <= '0;
      r_cap  <= '0;
    end else begin
      if (w_wr && avs.address == ADDR_IRQ_MASK) r_mask <= avs.writedata[WIDTH-1:0];
      r_cap <= (r_cap & ~w_clear) | w_edge;
    end
  end

  // Zero-latency read mux; chipselect does not gate read data.
  always_comb begin
    w_rdata = '0;
    case (avs.address)
      ADDR_DATA:     w_rdata[WIDTH-1:0] = w_sample;
      ADDR_IRQ_MASK: w_rdata[WIDTH-1:0] = r_mask;
      ADDR_EDGE_CAP: w_rdata[WIDTH-1:0] = r_cap;
      default:       w_rdata = '0;
    endcase
  end

  assign avs.readdata = w_rdata;
  assign avs.irq      = |(r_cap & r_mask);

endmodule

// File: doc/nios_sys_pio_dtmf_key_in.md
# nios_sys_pio_dtmf_key_in

Avalon-MM slave input PIO that brings the DTMF receiver outputs (4-bit tone code plus the StD "tone valid" strobe) into the Nios II system. It is the read-side counterpart of the DTMF enable output PIO on the same bus. Each input bit is synchronised, optionally debounced, and edge-detected into a sticky capture register. A maskable interrupt lets firmware service key presses without polling.

## Interface
- WIDTH, 5: number of input bits; bits [3:0] are the tone code Q1..Q4, bit 4 is StD.
- EDGE_TYPE, 0: edge captured per bit; 0 = rising, 1 = falling, 2 = any.
- DEBOUNCE_CYCLES, 16: stable-sample count for the debounce filter; only used when the filter is compiled in; must be at least 2.
- clk  in  1  system clock; all logic runs on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  word address within the slave.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous inputs from the DTMF receiver.
- readdata  out  32  read data, combinational, read latency 0.
- irq  out  1  level interrupt to the Nios II.

## Operation
- Write = chipselect & ~write_n. Read data depends only on address (chipselect ignored) and is zero-extended above WIDTH.
- Address 0, DATA (RO): synchronised, or filtered, input value `sample`. Writes are ignored.
- Address 1, reserved: reads 0; writes are ignored.
- Address 2, IRQ_MASK (RW): writedata[WIDTH-1:0] is stored; reads return the stored value.
- Address 3, EDGE_CAP (R/W1C): reads return the capture bits. A write clears every bit where writedata is 1 and leaves the other bits unchanged.
- Synchroniser: two flops, sync1 <= in_port and sync2 <= sync1, followed by prev <= sample.
- Edge detect per bit:
  - rising: sample & ~prev
  - falling: ~sample & prev
  - any: sample ^ prev
- Capture: cap <= (cap & ~clear) | edge.
  - If an edge and a W1C clear hit the same bit in the same cycle, the set wins.
- irq = |(cap & IRQ_MASK), combinational from registers.
- Warm-up:
  - A 2-bit counter runs from 0 to 3 after reset release.
  - Edge detection is forced to 0 until the counter saturates.
  - This prevents inputs that are held static through reset from producing spurious captures.
- Reset values:
  - sync1, sync2, prev, sample, cap, IRQ_MASK and the warm-up counter are all 0.
  - Consequently readdata = 0 at address 0, 2 and 3, and irq = 0.
- Reset asserted mid-operation clears all state immediately, including pending captures and the mask.

## Timing
- Input that is stable before rising edge E1:
  - sync1 updates at E1.
  - sync2 updates at E2; with no filter, DATA reads the new value after E2.
  - cap sets at E3.
  - irq rises after E3 if the bit is masked on.
- Filter compiled in: sample changes DEBOUNCE_CYCLES edges after sync2 first shows the new value, provided sync2 holds that value throughout. Capture follows one edge later.
- Pulses shorter than 2 clocks may be missed when the filter is out. When the filter is in, pulses shorter than DEBOUNCE_CYCLES are always rejected.
- Register writes take effect at the next clock edge. IRQ_MASK changes affect irq in the following cycle.
- W1C clear: cap bit is 0 after the write edge, and irq drops in the same cycle it updates.

## Configuration
- Macro: NIOS_SYS_PIO_DTMF_KEY_IN_DEBOUNCE_EN.
- Defined: each bit has a counter that resets whenever sync2 differs from sample.
  - sample <= sync2 once sync2 has differed from sample for DEBOUNCE_CYCLES consecutive cycles.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Undefined: sample <= sync2 every cycle, with no counters generated.

## Structure
- Shared package nios_sys_pio_pkg holds:
  - address constants ADDR_DATA = 0, ADDR_RSVD = 1, ADDR_IRQ_MASK = 2, ADDR_EDGE_CAP = 3.
  - edge-type encoding EDGE_RISE = 0, EDGE_FALL = 1, EDGE_ANY = 2.
- Sub-module nios_sys_pio_debounce: a single-bit stable-count filter instantiated WIDTH times. It is compiled only under the macro.

## Test plan
- Reset with in_port = 5'h1F held → after release, DATA reads 0x1F within 3 cycles, EDGE_CAP reads 0 and irq = 0.
- IRQ_MASK = 0x10; in_port goes from 0x00 to 0x1A (StD = 1, code 0xA) → after 3 cycles, EDGE_CAP = 0x1A, irq = 1. Write 0x10 to address 3 → EDGE_CAP = 0x0A, irq = 0.
- EDGE_TYPE = 1; in_port goes from 0x1F to 0x0F → EDGE_CAP = 0x10; a later 0x0F to 0x1F transition leaves EDGE_CAP unchanged.
- Capture bit 4 set; write 0x10 to address 3 in the same cycle a new rising edge on bit 4 reaches edge detect → EDGE_CAP[4] = 1.
- Filter in, DEBOUNCE_CYCLES = 16:
  - a 10-cycle glitch on bit 0 leaves DATA and EDGE_CAP at 0.
  - a 20-cycle pulse sets EDGE_CAP[0] 19 cycles after the pin change.
- Write 0xFFFFFFFF to address 0 and to address 1 → DATA unchanged, address 1 reads 0. Assert reset mid-capture → EDGE_CAP = 0, IRQ_MASK = 0, irq = 0.
